// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage register: FSM state encoding, the default
// MEM/WB payload layout and a helper that maps a state onto an entry count.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } mem_wb_t;

  localparam int MEM_WB_W = $bits(mem_wb_t);

  // Number of entries held in a given state.
  function automatic logic [1:0] state_occupancy(input pipe_state_t st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_reg_skid_sat_counter.sv
// Saturating event counter: counts cycles with inc=1 and sticks at all-ones.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Advance on each requested event until the top value is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= CNT_ZERO;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and a saturating stall counter. The main register
// always drives out_data; the skid register only catches the entry that arrives
// while the main one is blocked downstream.
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W         = MEM_WB_W,
  parameter bit SKID_EN        = 1'b1,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  pipe_state_t       state_r;
  pipe_state_t       state_next_s;
  logic [DATA_W-1:0] main_r;
  logic [DATA_W-1:0] main_next_s;
  logic [DATA_W-1:0] skid_r;
  logic [DATA_W-1:0] skid_next_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [1:0]        occupancy_r;
  logic              in_ready_s;
  logic              accept_s;
  logic              emit_s;
  logic              stall_inc_s;

  // With the skid buffer the ready is a flop; without it ready must look through
  // to out_ready so a single register can still stream one entry per cycle.
  if (SKID_EN) begin : g_skid_ready
    assign in_ready_s = in_ready_r;
  end else begin : g_direct_ready
    assign in_ready_s = out_ready | ~out_valid_r;
  end

  assign accept_s    = in_valid & in_ready_s;
  assign emit_s      = out_valid_r & out_ready;
  assign stall_inc_s = in_valid & ~in_ready_s;

  // Next-state and payload selection; flush overrides every transfer.
  always_comb begin
    state_next_s = state_r;
    main_next_s  = main_r;
    skid_next_s  = skid_r;
    if (flush) begin
      state_next_s = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_next_s = ZERO_DATA;
        skid_next_s = ZERO_DATA;
      end else begin
        main_next_s = main_r;
        skid_next_s = skid_r;
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_next_s = ST_ONE;
            main_next_s  = in_data;
          end else begin
            state_next_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && emit_s) begin
            state_next_s = ST_ONE;
            main_next_s  = in_data;
          end else if (accept_s) begin
            // Only reachable with the skid buffer: without it a blocked
            // output also blocks the input.
            if (SKID_EN) begin
              state_next_s = ST_TWO;
              skid_next_s  = in_data;
            end else begin
              state_next_s = ST_ONE;
            end
          end else if (emit_s) begin
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (emit_s) begin
            state_next_s = ST_ONE;
            main_next_s  = skid_r;
          end else begin
            state_next_s = ST_TWO;
          end
        end
        default: begin
          state_next_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State, payload and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_EMPTY;
      main_r      <= ZERO_DATA;
      skid_r      <= ZERO_DATA;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_next_s;
      main_r      <= main_next_s;
      skid_r      <= skid_next_s;
      in_ready_r  <= (state_next_s != ST_TWO);
      out_valid_r <= (state_next_s != ST_EMPTY);
      occupancy_r <= state_occupancy(state_next_s);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc_s),
    .count (stall_count)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = occupancy_r;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid. Three instances share one stimulus stream:
// u_a (defaults), u_s (4-bit stall counter) and u_n (no skid buffer).
// Each is tracked by a FIFO-of-entries reference model.
module tb_pipe_reg_skid;

  localparam int DW = 104;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = {DW{1'b0}};

  logic          a_in_ready, a_out_valid, s_in_ready, s_out_valid, n_in_ready, n_out_valid;
  logic [DW-1:0] a_out_data, s_out_data, n_out_data;
  logic [1:0]    a_occ, s_occ, n_occ;
  logic [15:0]   a_stall, n_stall;
  logic [3:0]    s_stall;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_reg_skid u_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_count(a_stall));

  pipe_reg_skid #(.CNT_W(4)) u_s (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occ), .stall_count(s_stall));

  pipe_reg_skid #(.SKID_EN(1'b0)) u_n (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .occupancy(n_occ), .stall_count(n_stall));

  // Gather the three instances' outputs into arrays for looped checking.
  logic          o_ready[3];
  logic          o_valid[3];
  logic [DW-1:0] o_data[3];
  logic [1:0]    o_occ[3];
  int            o_stall[3];
  always_comb begin
    o_ready[0] = a_in_ready;  o_valid[0] = a_out_valid; o_data[0] = a_out_data;
    o_ready[1] = s_in_ready;  o_valid[1] = s_out_valid; o_data[1] = s_out_data;
    o_ready[2] = n_in_ready;  o_valid[2] = n_out_valid; o_data[2] = n_out_data;
    o_occ[0] = a_occ; o_occ[1] = s_occ; o_occ[2] = n_occ;
    o_stall[0] = int'(a_stall); o_stall[1] = int'(s_stall); o_stall[2] = int'(n_stall);
  end

  // Reference model: per instance a FIFO (head, tail, count) plus a stall tally.
  // The head doubles as the value the output register shows when nothing is held.
  logic [DW-1:0] m_q0[3];
  logic [DW-1:0] m_q1[3];
  int            m_cnt[3];
  int            m_stall[3];

  function automatic logic exp_ready(input int id);
    if (id == 2) return (m_cnt[id] == 0) || out_ready;
    return m_cnt[id] < 2;
  endfunction

  function automatic int stall_max(input int id);
    return (id == 1) ? 15 : 65535;
  endfunction

  function automatic logic do_push(input int id);
    return in_valid && exp_ready(id);
  endfunction

  function automatic logic do_pop(input int id);
    return (m_cnt[id] > 0) && out_ready;
  endfunction

  function automatic logic [DW-1:0] next_head(input int id);
    int rem;
    rem = m_cnt[id] - int'(do_pop(id));
    if (do_pop(id)) return (rem >= 1) ? m_q1[id] : (do_push(id) ? in_data : m_q0[id]);
    return (m_cnt[id] >= 1) ? m_q0[id] : (do_push(id) ? in_data : m_q0[id]);
  endfunction

  function automatic logic [DW-1:0] next_tail(input int id);
    int rem;
    rem = m_cnt[id] - int'(do_pop(id));
    return (do_push(id) && rem == 1) ? in_data : m_q1[id];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int id = 0; id < 3; id++) begin
        m_cnt[id] <= 0; m_stall[id] <= 0;
        m_q0[id] <= {DW{1'b0}}; m_q1[id] <= {DW{1'b0}};
      end
    end else begin
      for (int id = 0; id < 3; id++) begin
        if (in_valid && !exp_ready(id) && (m_stall[id] < stall_max(id)))
          m_stall[id] <= m_stall[id] + 1;
        if (flush) begin
          m_cnt[id] <= 0;
          m_q0[id] <= {DW{1'b0}}; m_q1[id] <= {DW{1'b0}};
        end else begin
          m_cnt[id] <= m_cnt[id] - int'(do_pop(id)) + int'(do_push(id));
          m_q0[id] <= next_head(id);
          m_q1[id] <= next_tail(id);
        end
      end
    end
  end

  task automatic test_reset();
    #3;
    reset = 1'b0; in_valid = 1'b1; in_data = 104'h12345678;
    #1;
    vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", a_out_valid); end
    vectors++; if (a_out_data !== {DW{1'b0}}) begin miscompares++; $display("FAIL reset_data: got %0h expected 0", a_out_data); end
    vectors++; if (a_occ !== 2'd0) begin miscompares++; $display("FAIL reset_occ: got %0d expected 0", a_occ); end
    vectors++; if (a_stall !== 16'd0) begin miscompares++; $display("FAIL reset_stall: got %0d expected 0", a_stall); end
    vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %0b expected 1", a_in_ready); end
    @(negedge clk);
    vectors++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_held: ready %0b valid %0b expected 1/0", a_in_ready, a_out_valid); end
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (a_in_ready !== 1'b1 || a_occ !== 2'd0) begin miscompares++; $display("FAIL reset_after: ready %0b occ %0d expected 1/0", a_in_ready, a_occ); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 104'hDEADBEEF;
    @(negedge clk);
    vectors++; if (a_out_valid !== 1'b1 || a_out_data !== 104'hDEADBEEF || a_occ !== 2'd1) begin miscompares++; $display("FAIL stream_a: valid %0b data %0h occ %0d expected 1 deadbeef 1", a_out_valid, a_out_data, a_occ); end
    in_data = 104'hCAFEBABE;
    @(negedge clk);
    vectors++; if (a_out_valid !== 1'b1 || a_out_data !== 104'hCAFEBABE || a_occ !== 2'd1) begin miscompares++; $display("FAIL stream_b: valid %0b data %0h occ %0d expected 1 cafebabe 1", a_out_valid, a_out_data, a_occ); end
    in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin miscompares++; $display("FAIL stream_drain: valid %0b occ %0d expected 0 0", a_out_valid, a_occ); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp3[3];
    int idx;
    logic pending;
    exp3[0] = 104'hA0A0_0001; exp3[1] = 104'hB0B0_0002; exp3[2] = 104'hC0C0_0003;
    out_ready = 1'b0; in_valid = 1'b1; in_data = exp3[0];
    @(negedge clk);
    vectors++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_one: occ %0d ready %0b expected 1 1", a_occ, a_in_ready); end
    in_data = exp3[1];
    @(negedge clk);
    vectors++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_stall !== 16'd0) begin miscompares++; $display("FAIL bp_two: occ %0d ready %0b stall %0d expected 2 0 0", a_occ, a_in_ready, a_stall); end
    in_data = exp3[2];
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++; if (a_in_ready !== 1'b0 || a_stall !== 16'(k) || a_out_data !== exp3[0]) begin miscompares++; $display("FAIL bp_hold: ready %0b stall %0d data %0h expected 0 %0d %0h", a_in_ready, a_stall, a_out_data, k, exp3[0]); end
    end
    out_ready = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 12 && idx < 3; cyc++) begin
      if (a_out_valid) begin
        vectors++; if (a_out_data !== exp3[idx]) begin miscompares++; $display("FAIL bp_order: got %0h expected %0h", a_out_data, exp3[idx]); end
        idx++;
      end
      pending = in_valid && a_in_ready;
      @(negedge clk);
      if (pending) in_valid = 1'b0;
    end
    vectors++; if (idx != 3) begin miscompares++; $display("FAIL bp_count: got %0d entries expected 3", idx); end
    vectors++; if (a_stall !== 16'd4 || a_occ !== 2'd0) begin miscompares++; $display("FAIL bp_final: stall %0d occ %0d expected 4 0", a_stall, a_occ); end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 104'hD1;
    @(negedge clk);
    in_data = 104'hD2;
    @(negedge clk);
    vectors++; if (a_occ !== 2'd2) begin miscompares++; $display("FAIL flush_fill: occ %0d expected 2", a_occ); end
    flush = 1'b1; in_data = 104'hD3;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== {DW{1'b0}} || a_in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_two: valid %0b occ %0d data %0h ready %0b expected 0 0 0 1", a_out_valid, a_occ, a_out_data, a_in_ready); end
    vectors++; if (a_stall !== 16'd5) begin miscompares++; $display("FAIL flush_stall: got %0d expected 5", a_stall); end
    in_valid = 1'b1; in_data = 104'hE1;
    @(negedge clk);
    in_data = 104'hE2; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== {DW{1'b0}}) begin miscompares++; $display("FAIL flush_accept: valid %0b occ %0d data %0h expected 0 0 0", a_out_valid, a_occ, a_out_data); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 104'h5A5A;
    for (int k = 0; k < 22; k++) @(negedge clk);
    vectors++; if (s_stall !== 4'd15) begin miscompares++; $display("FAIL sat_reach: got %0d expected 15", s_stall); end
    for (int k = 0; k < 3; k++) @(negedge clk);
    vectors++; if (s_stall !== 4'd15) begin miscompares++; $display("FAIL sat_hold: got %0d expected 15", s_stall); end
    vectors++; if (a_stall !== 16'd28) begin miscompares++; $display("FAIL sat_wide: got %0d expected 28", a_stall); end
    flush = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] rnd;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      in_data   = rnd[DW-1:0];
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      @(negedge clk);
      for (int id = 0; id < 3; id++) begin
        vectors++; if (o_ready[id] !== exp_ready(id)) begin miscompares++; $display("FAIL rnd_ready dut%0d: got %0b expected %0b", id, o_ready[id], exp_ready(id)); end
        vectors++; if (o_valid[id] !== (m_cnt[id] > 0)) begin miscompares++; $display("FAIL rnd_valid dut%0d: got %0b expected count %0d", id, o_valid[id], m_cnt[id]); end
        vectors++; if (o_occ[id] !== 2'(m_cnt[id])) begin miscompares++; $display("FAIL rnd_occ dut%0d: got %0d expected %0d", id, o_occ[id], m_cnt[id]); end
        vectors++; if (o_data[id] !== m_q0[id]) begin miscompares++; $display("FAIL rnd_data dut%0d: got %0h expected %0h", id, o_data[id], m_q0[id]); end
        vectors++; if (o_stall[id] != m_stall[id]) begin miscompares++; $display("FAIL rnd_stall dut%0d: got %0d expected %0d", id, o_stall[id], m_stall[id]); end
      end
      vectors++; if (n_occ > 2'd1) begin miscompares++; $display("FAIL noskid_occ: got %0d expected at most 1", n_occ); end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 104'h77;
    @(negedge clk);
    in_data = 104'h88;
    @(negedge clk);
    in_data = 104'h99;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== {DW{1'b0}} || a_stall !== 16'd0 || a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_mid: valid %0b occ %0d data %0h stall %0d ready %0b expected 0 0 0 0 1", a_out_valid, a_occ, a_out_data, a_stall, a_in_ready); end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || n_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid_after: valid %0b ready %0b nvalid %0b expected 0 1 0", a_out_valid, a_in_ready, n_out_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
